// File: rtl/arb_pkg.sv
// Shared definitions for the eight-requester round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ            = 8;
   localparam int unsigned IDX_W            = 3;
   localparam int unsigned DEFAULT_MAX_HOLD = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_e;

   function automatic logic [N_REQ-1:0] idxToOneHot(input logic [IDX_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin search: first set request strictly after lastIdx_i, wrapping 7 -> 0.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] lastIdx_i,
   output logic [IDX_W-1:0] pickIdx_o,
   output logic             pickValid_o
);

   logic [IDX_W-1:0]   startIdx;
   logic [2*N_REQ-1:0] reqDouble;
   logic [N_REQ-1:0]   reqRot;
   logic [IDX_W-1:0]   offset;

   // Rotate so the search start lands on bit 0, priority-encode, then rotate the index back.
   always_comb begin
      startIdx  = lastIdx_i + IDX_W'(1);
      reqDouble = {req_i, req_i};
      reqRot    = N_REQ'(reqDouble >> startIdx);
      offset    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (reqRot[i]) begin
            offset = IDX_W'(i);
         end
      end
      pickIdx_o   = startIdx + offset;
      pickValid_o = |req_i;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with hold-until-release grants and a MAX_HOLD timeout.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_i,
   input  logic             release_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] gntIdx_o,
   output logic             gntValid_o,
   output logic             timeout_o
);

   arbState_e        state_q,    state_d;
   logic [IDX_W-1:0] lastIdx_q,  lastIdx_d;
   logic [CNT_W-1:0] holdCnt_q,  holdCnt_d;
   logic [IDX_W-1:0] gntIdx_q,   gntIdx_d;
   logic             gntValid_q, gntValid_d;
   logic [N_REQ-1:0] gnt_q,      gnt_d;
   logic             timeout_q,  timeout_d;

   logic [IDX_W-1:0] pickIdx;
   logic             pickValid;
   logic             ownerReq;
   logic             holdExpired;

   rr_pick8 uPick (
      .req_i       (req_i),
      .lastIdx_i   (lastIdx_q),
      .pickIdx_o   (pickIdx),
      .pickValid_o (pickValid)
   );

   assign ownerReq    = req_i[gntIdx_q];
   assign holdExpired = (holdCnt_q == CNT_W'(MAX_HOLD));

   // Every exit from GRANT passes through IDLE, which gives the one-cycle bus turnaround.
   always_comb begin
      state_d    = state_q;
      lastIdx_d  = lastIdx_q;
      holdCnt_d  = holdCnt_q;
      gntIdx_d   = gntIdx_q;
      gntValid_d = gntValid_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pickValid) begin
               state_d    = GRANT;
               gntIdx_d   = pickIdx;
               gntValid_d = 1'b1;
               lastIdx_d  = pickIdx;
               holdCnt_d  = CNT_W'(1);
            end
         end
         GRANT: begin
            if (release_i || !ownerReq || holdExpired) begin
               state_d    = IDLE;
               gntIdx_d   = '0;
               gntValid_d = 1'b0;
               holdCnt_d  = '0;
               timeout_d  = holdExpired && !release_i;
            end else begin
               holdCnt_d  = holdCnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      gnt_d = gntValid_d ? idxToOneHot(gntIdx_d) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lastIdx_q  <= IDX_W'(N_REQ - 1);
         holdCnt_q  <= '0;
         gntIdx_q   <= '0;
         gntValid_q <= 1'b0;
         gnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lastIdx_q  <= lastIdx_d;
         holdCnt_q  <= holdCnt_d;
         gntIdx_q   <= gntIdx_d;
         gntValid_q <= gntValid_d;
         gnt_q      <= gnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign gnt_o      = gnt_q;
   assign gntIdx_o   = gntIdx_q;
   assign gntValid_o = gntValid_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized bench for rr_arbiter8 against a cycle-level behavioural model.
module tb_rr_arbiter8;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;
   logic       rel;
   logic [7:0] gnt;
   logic [2:0] gntIdx;
   logic       gntValid;
   logic       timeout;

   int compareCount  = 0;
   int mismatchCount = 0;

   // Reference model state: who owns the grant, for how long, and who was granted last.
   bit mInGrant;
   int mOwner;
   int mLast;
   int mHold;
   bit mTimeout;

   rr_arbiter8 #(.MAX_HOLD(MAXH), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req),
      .release_i  (rel),
      .gnt_o      (gnt),
      .gntIdx_o   (gntIdx),
      .gntValid_o (gntValid),
      .timeout_o  (timeout)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      mInGrant = 1'b0;
      mOwner   = 0;
      mLast    = 7;
      mHold    = 0;
      mTimeout = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs sampled at that edge.
   task automatic modelStep(input logic [7:0] r, input logic rl);
      mTimeout = 1'b0;
      if (!mInGrant) begin
         for (int k = 1; k <= 8; k++) begin
            if (r[(mLast + k) % 8]) begin
               mOwner   = (mLast + k) % 8;
               mLast    = mOwner;
               mInGrant = 1'b1;
               mHold    = 1;
               break;
            end
         end
      end else if (rl || !r[mOwner] || mHold == MAXH) begin
         mTimeout = (mHold == MAXH) && !rl;
         mInGrant = 1'b0;
         mOwner   = 0;
         mHold    = 0;
      end else begin
         mHold++;
      end
   endtask

   task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         mismatchCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, "_gnt"},   gnt,                 mInGrant ? (8'h01 << mOwner) : 8'h00);
      checkVal({tag, "_idx"},   {5'd0, gntIdx},      mInGrant ? 8'(mOwner) : 8'h00);
      checkVal({tag, "_valid"}, {7'd0, gntValid},    {7'd0, mInGrant});
      checkVal({tag, "_tmo"},   {7'd0, timeout},     {7'd0, mTimeout});
   endtask

   task automatic applyStimulus(input string tag, input logic [7:0] r, input logic rl);
      req = r;
      rel = rl;
      @(posedge clk);
      modelStep(r, rl);
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      logic [7:0] rndReq;
      logic       rndRel;

      rst_n = 1'b0;
      req   = 8'h00;
      rel   = 1'b0;
      modelReset();
      #12;
      checkOutput("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Reset priority: requester 0 first, then strict rotation with an idle gap after each release.
      for (int i = 0; i < 9; i++) begin
         applyStimulus("rp_grant", 8'hFF, 1'b0);
         checkVal("rp_idx", {5'd0, gntIdx}, 8'(i % 8));
         checkVal("rp_onehot", gnt, 8'h01 << (i % 8));
         applyStimulus("rp_rel", 8'hFF, 1'b1);
         checkVal("rp_gap", {7'd0, gntValid}, 8'h00);
      end

      // Wrap-around from last index 6.
      applyStimulus("wr_g6", 8'h40, 1'b0);
      applyStimulus("wr_r6", 8'h40, 1'b1);
      applyStimulus("wr_g0", 8'h41, 1'b0);
      checkVal("wr_first", gnt, 8'h01);
      applyStimulus("wr_r0", 8'h41, 1'b1);
      applyStimulus("wr_g6b", 8'h41, 1'b0);
      checkVal("wr_second", gnt, 8'h40);
      applyStimulus("wr_r6b", 8'h41, 1'b1);

      // Timeout: four granted cycles, a single timeout pulse, then a re-grant.
      for (int i = 0; i < 4; i++) begin
         applyStimulus("to_hold", 8'h08, 1'b0);
         checkVal("to_gnt", gnt, 8'h08);
      end
      applyStimulus("to_exp", 8'h08, 1'b0);
      checkVal("to_pulse", {7'd0, timeout}, 8'h01);
      checkVal("to_drop", gnt, 8'h00);
      applyStimulus("to_regrant", 8'h08, 1'b0);
      checkVal("to_regnt", gnt, 8'h08);
      checkVal("to_clear", {7'd0, timeout}, 8'h00);

      // Release in the same cycle the hold limit is reached suppresses the timeout.
      applyStimulus("col_h2", 8'h08, 1'b0);
      applyStimulus("col_h3", 8'h08, 1'b0);
      applyStimulus("col_h4", 8'h08, 1'b0);
      applyStimulus("col_rel", 8'h08, 1'b1);
      checkVal("col_tmo", {7'd0, timeout}, 8'h00);
      checkVal("col_gnt", gnt, 8'h00);

      // Owner drop: requester 5 lets go, next grant rotates onward to 7.
      applyStimulus("od_g5", 8'hA2, 1'b0);
      checkVal("od_own", gnt, 8'h20);
      applyStimulus("od_drop", 8'h82, 1'b0);
      checkVal("od_clear", gnt, 8'h00);
      checkVal("od_tmo", {7'd0, timeout}, 8'h00);
      applyStimulus("od_g7", 8'h82, 1'b0);
      checkVal("od_next", gnt, 8'h80);
      applyStimulus("od_rel", 8'h82, 1'b1);

      // Asynchronous reset mid-grant, checked between clock edges.
      applyStimulus("ar_g4", 8'h10, 1'b0);
      checkVal("ar_own", gnt, 8'h10);
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("ar_async");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("ar_first", 8'h11, 1'b0);
      checkVal("ar_idx0", gnt, 8'h01);
      applyStimulus("ar_rel", 8'h11, 1'b1);

      // Randomized traffic with sticky requests so timeouts and drops both occur.
      rndReq = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            rndReq = 8'($urandom_range(0, 255));
         end
         rndRel = ($urandom_range(0, 4) == 0);
         applyStimulus("rnd", rndReq, rndRel);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
